// File: rtl/display_pkg.sv
// display_pkg: shared seven-segment encoding and BCD/segment widths
package display_pkg;
  localparam int BCD_W = 4;
  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  // Active-low segments {dp,g,f,e,d,c,b,a} for BCD 9..0, digit 0 in the LSBs
  localparam logic [10*SEG_W-1:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] v);
    return v < 4'd10 ? SEG_TABLE[int'(v)*SEG_W +: SEG_W] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and edge-detect one active-low push-key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [1:0] vld;
  logic level;
  logic armed;
  logic [CW-1:0] cnt;
  logic accept;
  assign accept = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Presses are only honoured once the key has been seen released after reset,
  // so a key held through reset cannot generate an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      vld   <= 2'b00;
      level <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & sync[1]);
      cnt   <= (sync[1] == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? sync[1] : level;
      press <= accept & ~sync[1] & armed;
    end
  end
endmodule

// File: rtl/date_display_ctrl.sv
// date_display_ctrl: switch-to-LED mirror with invert toggle and date table on HEX digits
module date_display_ctrl
  import display_pkg::*;
#(
  parameter int SW_WIDTH = 8,
  parameter int LED_WIDTH = 10,
  parameter int NUM_DIGITS = 6,
  parameter int NUM_DATES = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_DATES*NUM_DIGITS*BCD_W-1:0] DATE_TABLE =
    {24'hFFFFFF, 24'hFFFFFF, 24'h082401, 24'h082301}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SW_WIDTH-1:0]         switch,
  input  logic [1:0]                  key,
  output logic [LED_WIDTH-1:0]        leds,
  output logic [SEG_W*NUM_DIGITS-1:0] hex
);
  localparam int IDX_W = $clog2(NUM_DATES);
  localparam int ENTRY_W = NUM_DIGITS * BCD_W;
  logic [SW_WIDTH-1:0] sw_meta, sw_sync;
  logic [1:0] press;
  logic invert_q;
  logic [IDX_W-1:0] date_idx;
  logic [ENTRY_W-1:0] entry;
  logic [SW_WIDTH-1:0] sw_val;
  logic [LED_WIDTH-1:0] leds_d;
  logic [SEG_W*NUM_DIGITS-1:0] hex_d;
  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .key(key[k]), .press(press[k])
    );
  end
  // Two-flop synchroniser for the slide switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end
  // Key events: key[0] toggles invert, key[1] steps through the date table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invert_q <= 1'b0;
      date_idx <= '0;
    end else begin
      invert_q <= invert_q ^ press[0];
      if (press[1]) date_idx <= (date_idx == IDX_W'(NUM_DATES - 1)) ? '0 : date_idx + 1'b1;
    end
  end
  // Select the current date entry and decode each digit to segments
  always_comb begin
    entry  = DATE_TABLE[int'(date_idx)*ENTRY_W +: ENTRY_W];
    sw_val = invert_q ? ~sw_sync : sw_sync;
    leds_d = (LED_WIDTH'(date_idx) << SW_WIDTH) | LED_WIDTH'(sw_val);
    hex_d  = '0;
    for (int d = 0; d < NUM_DIGITS; d++) hex_d[d*SEG_W +: SEG_W] = seg_encode(entry[d*BCD_W +: BCD_W]);
  end
  // Registered board outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= '0;
      hex  <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      leds <= leds_d;
      hex  <= hex_d;
    end
  end
endmodule

// File: doc/date_display_ctrl.md
# date_display_ctrl

Parametrised board-level front-panel controller. It mirrors the switch bank onto the LEDs with a latched, key-toggled invert mode, and cycles a six-digit seven-segment display through a table of stored BCD dates on key presses. It sits directly behind the board pins: switches, push-keys, LEDs and HEX displays. All inputs are synchronised and debounced, and all outputs are registered.

## Interface
- SW_WIDTH, 8: number of switches mirrored onto the low LEDs.
- LED_WIDTH, 10: total LEDs; must be >= SW_WIDTH.
- NUM_DIGITS, 6: number of seven-segment digits.
- NUM_DATES, 4: number of table entries; must be >= 2.
- DEBOUNCE_CYCLES, 500000: stable-sample count before a key level is accepted (10 ms at 50 MHz).
- DATE_TABLE, {24'hFFFFFF, 24'hFFFFFF, 24'h082401, 24'h082301}: NUM_DATES × NUM_DIGITS × 4 bits of packed BCD. Entry 0 is in the LSBs, and digit 0 is the low nibble of each entry.
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- switch, input, SW_WIDTH: raw slide switches, asynchronous.
- key, input, 2: raw push-keys, active-low (0 = pressed), asynchronous.
- leds, output, LED_WIDTH: LED drive, 1 = lit.
- hex, output, 8×NUM_DIGITS: segment drive, active-low. Digit d occupies hex[8d+7:8d]; bit 7 is the decimal point, bits 6..0 are segments g..a.

## Operation
- Synchronisers:
  - switch and key each pass through a 2-flop synchroniser.
  - Synchroniser reset values: switch = 0, key = 2'b11 (released).
- Debounce (per key):
  - A counter increments while the synchronised sample differs from the accepted level, and clears to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the accepted level takes the sample value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
  - Accepted level resets to 1.
- Press event: a one-cycle pulse when the accepted level goes 1→0. Release produces no event.
- key[0] press toggles invert_q (reset value 0).
- key[1] press advances date_idx (reset value 0) by 1, wrapping from NUM_DATES-1 to 0.
- Simultaneous presses: both events take effect in the same cycle.
- Holding a key produces exactly one event. Auto-repeat is not supported.
- LED outputs:
  - leds[SW_WIDTH-1:0] = invert_q ? ~switch_sync : switch_sync.
  - leds[LED_WIDTH-1:SW_WIDTH] = date_idx, zero-extended or truncated to fit.
- Digit decoding:
  - Each nibble of DATE_TABLE entry date_idx is decoded to segments for values 0–9.
  - Values 0xA–0xF produce blank (8'hFF).
  - The decimal point is always off (bit 7 = 1).
- Reset values: leds = 0, hex = all 8'hFF.
- Asserting rst_n low mid-debounce discards the pending count and any in-progress press.

## Timing
- Switch to LED: a switch change sampled at edge n appears on leds after edge n+2 (2 sync edges + 1 output register).
- Key to output:
  - Pin level first sampled at edge n.
  - Accepted level changes at edge n+1+DEBOUNCE_CYCLES.
  - Press event pulse is high during the following cycle.
  - invert_q / date_idx update at edge n+2+DEBOUNCE_CYCLES.
  - leds / hex show the result after edge n+3+DEBOUNCE_CYCLES.
- The switch path and key path are independent. A switch change in the same cycle as an invert toggle applies both in one output update.
- All state is on rising clk. rst_n clears all state immediately (asynchronous); release of rst_n takes effect at the next clk edge.

## Structure
- Shared package display_pkg holds:
  - the seven-segment encode table for BCD 0–9;
  - SEG_BLANK = 8'hFF;
  - BCD_W = 4 and SEG_W = 8.
- Sub-module key_debounce contains the 2-flop synchroniser, counter, accepted level and press pulse. It has a DEBOUNCE_CYCLES parameter and is instantiated once per key via generate.
- Top level contains invert_q, date_idx, the table mux, the segment decode, and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. Reset: hold rst_n = 0 for 3 cycles → leds = 10'h000, hex = 48'hFFFFFFFFFFFF; release rst_n, switch = 8'hA5 → leds = 10'h0A5 after 3 cycles.
2. key[0] pulled low for 8 cycles then released → leds = 10'h05A (~0xA5, index bits 00); a second press returns leds to 10'h0A5.
3. key[1] glitch low for 3 cycles → no change. key[1] low for 8 cycles → date_idx = 1 and digits 5..0 show 0,8,2,4,0,1 (digit 2 = 7'b0011001 pattern for "4").
4. Press key[1] four times from reset → idx sequence 1, 2, 3, 0; entries 2 and 3 give all hex = 8'hFF (blank); wrap returns to 082301; leds[9:8] track 01, 10, 11, 00.
5. key[0] and key[1] pressed on the same cycle → invert toggles and idx advances in the same output update.
6. rst_n asserted after 2 of 4 debounce cycles of a key[1] press → idx = 0 and no event after release of rst_n while the key is still held, until the key has been released and pressed again.
